// File: rtl/b6_rr_arbiter_if.sv
// Request/grant bundle between the requesting units and the b6 round-robin arbiter.
interface b6_rr_arbiter_if;
  logic        enable;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        timeout;

  modport master (
    output enable, req, done,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  enable, req, done,
    output grant, grant_id, grant_valid, timeout
  );
endinterface

// File: rtl/b6_rr_arbiter.sv
// Sixteen-requester round-robin arbiter: rotating-origin priority search (highest index first),
// grant held until done, request withdrawal, enable drop, or MAX_HOLD cycles elapse.
module b6_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  b6_rr_arbiter_if.slave   bus
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t          r_state;
  logic [3:0]      r_ptr;
  logic [3:0]      r_w;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_grant;
  logic [3:0]      r_grant_id;
  logic            r_grant_valid;
  logic            r_timeout;

  logic            w_found;
  logic [3:0]      w_winner;
  logic [3:0]      w_idx;
  logic            w_at_limit;
  logic            w_owner_quit;
  logic            w_release;

  // Search downward from ptr with 4-bit wrap; first set request wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      w_idx = r_ptr - 4'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_at_limit   = (r_cnt == CW'(MAX_HOLD));
    w_owner_quit = bus.done || !bus.req[r_w] || !bus.enable;
    w_release    = w_owner_quit || w_at_limit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= 4'd15;
      r_w           <= '0;
      r_cnt         <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable && w_found) begin
            r_state       <= S_GRANT;
            r_w           <= w_winner;
            r_grant       <= 16'(1) << w_winner;
            r_grant_id    <= w_winner;
            r_grant_valid <= 1'b1;
            r_cnt         <= CW'(1);
            r_ptr         <= w_winner - 4'd1;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            // Only a pure limit expiry counts as a timeout; any owner-side release takes precedence.
            r_timeout     <= w_at_limit && !w_owner_quit;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_id    = r_grant_id;
  assign bus.grant_valid = r_grant_valid;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_b6_rr_arbiter.sv
// Directed bench for b6_rr_arbiter: one instance with MAX_HOLD=8, one with MAX_HOLD=1.
module tb_b6_rr_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  b6_rr_arbiter_if a ();
  b6_rr_arbiter_if b ();

  b6_rr_arbiter #(.MAX_HOLD(8)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a.slave)
  );

  b6_rr_arbiter #(.MAX_HOLD(1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {grant, grant_id, grant_valid, timeout}
  function automatic logic [21:0] eg(input int id);
    logic [15:0] g;
    g = '0;
    g[id] = 1'b1;
    return {g, 4'(id), 1'b1, 1'b0};
  endfunction

  function automatic logic [21:0] ei(input logic t);
    return {16'h0000, 4'h0, 1'b0, t};
  endfunction

  function automatic logic [21:0] obs_a();
    return {a.grant, a.grant_id, a.grant_valid, a.timeout};
  endfunction

  function automatic logic [21:0] obs_b();
    return {b.grant, b.grant_id, b.grant_valid, b.timeout};
  endfunction

  task automatic chk(input string tag, input logic [21:0] observed, input logic [21:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed grant=%h id=%0d v=%b to=%b expected grant=%h id=%0d v=%b to=%b",
             tag, observed[21:6], observed[5:2], observed[1], observed[0],
             expected[21:6], expected[5:2], expected[1], expected[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    a.enable = 1'b0; a.req = '0; a.done = 1'b0;
    b.enable = 1'b0; b.req = '0; b.done = 1'b0;
    step();
    step();
    chk("reset_a", obs_a(), ei(1'b0));
    chk("reset_b", obs_b(), ei(1'b0));

    // Fixed-priority behaviour right after reset, then rotation.
    reset = 1'b0;
    a.enable = 1'b1;
    a.req = 16'h8001;
    step();
    chk("first_15", obs_a(), eg(15));
    a.done = 1'b1;
    step();
    chk("gap_after_15", obs_a(), ei(1'b0));
    a.done = 1'b0;
    step();
    chk("then_0", obs_a(), eg(0));
    a.req = '0;
    step();
    chk("req_drop_idle", obs_a(), ei(1'b0));

    // Full rotation 15..0 then 15, one gap per grant.
    a.req = 16'hFFFF;
    for (int j = 0; j < 17; j++) begin
      step();
      chk($sformatf("rot_%0d", j), obs_a(), eg((15 - j) & 15));
      a.done = 1'b1;
      step();
      chk($sformatf("rot_gap_%0d", j), obs_a(), ei(1'b0));
      a.done = 1'b0;
    end

    // Hold limit: 8 held cycles, timeout pulse, regrant.
    a.req = 16'h0008;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk($sformatf("hold_%0d", j), obs_a(), eg(3));
    end
    step();
    chk("timeout_pulse", obs_a(), ei(1'b1));
    step();
    chk("regrant_3", obs_a(), eg(3));
    a.req = '0;
    step();
    chk("req3_drop", obs_a(), ei(1'b0));

    // Withdraw req[5] mid-grant: no timeout.
    a.req = 16'h0020;
    step();
    chk("grant_5", obs_a(), eg(5));
    a.req = '0;
    step();
    chk("req5_drop", obs_a(), ei(1'b0));

    // done coinciding with the limit is not a timeout.
    a.req = 16'h0008;
    for (int j = 1; j <= 8; j++) step();
    chk("limit_hold8", obs_a(), eg(3));
    a.done = 1'b1;
    step();
    chk("done_at_limit", obs_a(), ei(1'b0));
    a.done = 1'b0;

    // Enable drop revokes and blocks grants (ptr=2 here).
    a.req = 16'hFFFF;
    step();
    chk("en_grant_2", obs_a(), eg(2));
    a.enable = 1'b0;
    step();
    chk("en_revoke", obs_a(), ei(1'b0));
    step();
    chk("en_blocked1", obs_a(), ei(1'b0));
    step();
    chk("en_blocked2", obs_a(), ei(1'b0));
    a.enable = 1'b1;
    step();
    chk("en_resume_1", obs_a(), eg(1));

    // Reset mid-grant restores ptr=15.
    a.req = 16'h8004;
    step();
    chk("rst_pre_idle", obs_a(), ei(1'b0));
    step();
    chk("rst_pre_15", obs_a(), eg(15));
    a.done = 1'b1;
    step();
    a.done = 1'b0;
    step();
    chk("rst_grant_2", obs_a(), eg(2));
    reset = 1'b1;
    step();
    chk("rst_mid", obs_a(), ei(1'b0));
    reset = 1'b0;
    step();
    chk("rst_after_15", obs_a(), eg(15));

    // MAX_HOLD=1: alternating 1,0 with timeout pulses.
    a.enable = 1'b0;
    b.enable = 1'b1;
    b.req = 16'h0003;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("mh1_grant_%0d", j), obs_b(), eg((j % 2 == 0) ? 1 : 0));
      step();
      chk($sformatf("mh1_to_%0d", j), obs_b(), ei(1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
